vec_add_arbiter: RTL

Shared-resource arbiter and sequencer for the ray tracer's 57-bit packed vector adder. Up to NUM_REQ pipeline units compete for one adder, for example:
- ray generator (origin + direction step)
- intersection unit (hit point)
- shading unit (normal offset)

Round-robin arbitration selects one valid request per cycle. The block performs the per-lane {x, y, z} fixed-point addition and holds the result in a one-entry output register. The result carries the requester ID back to the requester.

---
 rtl/ray_pkg.sv | 29 ++
 rtl/vec_add_lane.sv | 36 +++
 rtl/vec_add_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ray_pkg.sv
// Shared ray-tracer vector types and constants.
// Packed vector layout: x[56:38], y[37:19], z[18:0], each lane 19-bit signed
// fixed point (9 integer bits including sign, 10 fraction bits).
package ray_pkg;

    localparam int unsigned VECTOR_WIDTH = 57;
    localparam int unsigned COORD_W      = 19;
    localparam int unsigned FRAC_W       = 10;

    localparam int unsigned X_LSB = 38;
    localparam int unsigned Y_LSB = 19;
    localparam int unsigned Z_LSB = 0;

    localparam logic [COORD_W-1:0] COORD_MAX = 19'h3FFFF;
    localparam logic [COORD_W-1:0] COORD_MIN = 19'h40000;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } vec3_t;

    // Output register occupancy; FULL is exactly resp_valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage : ray_pkg

// File: rtl/vec_add_lane.sv
// One 19-bit signed fixed-point lane adder (combinational).
// Optional macro VEC_ADD_SAT_EN: saturate on overflow instead of wrapping.
// Ports:
//   a_i, b_i : lane operands
//   sum_o    : lane sum (wrapped, or clamped when saturation is enabled)
module vec_add_lane
    import ray_pkg::*;
(
    input  logic [COORD_W-1:0] a_i,
    input  logic [COORD_W-1:0] b_i,
    output logic [COORD_W-1:0] sum_o
);

`ifdef VEC_ADD_SAT_EN
    logic [COORD_W-1:0] raw_sum;
    logic               ovf;

    // Overflow: operands share a sign and the sum's sign differs.
    always_comb begin
        raw_sum = a_i + b_i;
        ovf     = (a_i[COORD_W-1] == b_i[COORD_W-1]) &&
                  (raw_sum[COORD_W-1] != a_i[COORD_W-1]);
        if (ovf) begin
            sum_o = a_i[COORD_W-1] ? COORD_MIN : COORD_MAX;
        end else begin
            sum_o = raw_sum;
        end
    end
`else
    // Two's-complement wrap: the carry out of the lane is dropped.
    always_comb begin
        sum_o = a_i + b_i;
    end
`endif

endmodule : vec_add_lane

// File: rtl/vec_add_arbiter.sv
// Round-robin arbiter + one-entry output register for the shared 57-bit
// packed vector adder. Optional macro VEC_ADD_SAT_EN selects saturating lanes.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   req_valid/req_ready    : per-requester handshake (req_ready one-hot, comb)
//   req_vec_a/req_vec_b    : operands, requester i at [i*57 +: 57]
//   resp_valid/resp_ready  : result handshake
//   resp_vec, resp_id      : registered sum and producing requester index
module vec_add_arbiter
    import ray_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned VECTOR_WIDTH = 57,
    parameter int unsigned ID_W         = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*VECTOR_WIDTH-1:0] req_vec_a,
    input  logic [NUM_REQ*VECTOR_WIDTH-1:0] req_vec_b,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [VECTOR_WIDTH-1:0]         resp_vec,
    output logic [ID_W-1:0]                 resp_id
);

    out_state_e        state_q, state_d;
    vec3_t             vec_q;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   rr_ptr_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_found;
    logic               can_accept;
    logic               xfer;
    logic [ID_W-1:0]    rr_next;
    vec3_t              a_sel, b_sel, sum_d;

    // Round-robin search upward from rr_ptr, modulo NUM_REQ.
    always_comb begin
        int unsigned idx;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!gnt_found && req_valid[idx[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(idx);
            end
        end
        grant = '0;
        if (gnt_found) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    // Handshake: accept whenever the output register is empty or draining.
    always_comb begin
        can_accept = (state_q == ST_EMPTY) || resp_ready;
        xfer       = gnt_found && can_accept && !rst;
        req_ready  = xfer ? grant : '0;
        rr_next    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end

    // Operand mux driven by the one-hot grant.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel = vec3_t'(req_vec_a[i*VECTOR_WIDTH +: VECTOR_WIDTH]);
                b_sel = vec3_t'(req_vec_b[i*VECTOR_WIDTH +: VECTOR_WIDTH]);
            end
        end
    end

    vec_add_lane u_lane_x (.a_i(a_sel.x), .b_i(b_sel.x), .sum_o(sum_d.x));
    vec_add_lane u_lane_y (.a_i(a_sel.y), .b_i(b_sel.y), .sum_o(sum_d.y));
    vec_add_lane u_lane_z (.a_i(a_sel.z), .b_i(b_sel.z), .sum_o(sum_d.z));

    // State, result and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            vec_q    <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                vec_q    <= sum_d;
                id_q     <= gnt_idx;
                rr_ptr_q <= rr_next;
            end
        end
    end

    // Next state: a transfer always fills; a drain without transfer empties.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (xfer) state_d = ST_FULL;
            ST_FULL:  if (!xfer && resp_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        resp_valid = (state_q == ST_FULL);
        resp_vec   = VECTOR_WIDTH'(vec_q);
        resp_id    = id_q;
    end

endmodule : vec_add_arbiter
